irq_request_latch: RTL and testbench
====================================

Name: irq_request_latch

Overview:
- Upstream stage of the 8-input priority encoder. It synchronises 8 asynchronous request lines, captures them as pending bits in edge or level mode, and applies a mask.
- It drives the encoder's request vector `a_out` and enable `en_out`.
- Pending bits are cleared by index acknowledge from the consumer of the encoder output. Requests that arrive while already pending are flagged as overflow.

Parameters:
- N, 8, number of request lines.
- IDX_W, 3, acknowledge index width (clog2 N).
- SYNC_STAGES, 2, synchroniser depth; legal values 2..3.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_in  input  N  asynchronous request lines, active high.
- mask  input  N  1 = request enabled to output; synchronous to clk.
- edge_mode  input  1  1 = rising-edge capture, 0 = level capture; quasi-static.
- ack_valid  input  1  acknowledge strobe, one cycle.
- ack_idx  input  IDX_W  index of pending bit to clear.
- clr_ovf  input  1  clears all overflow flags.
- a_out  output  N  masked pending vector to the encoder.
- en_out  output  1  high when any bit of a_out is set.
- pending  output  N  raw (unmasked) pending register.
- overflow  output  N  sticky per-line overflow flags.

Behaviour:
- Reset (rst_n low, asynchronous): synchroniser flops, edge-delay flops, pending, overflow and the registered edge_mode copy all go to 0.
  - a_out = 0 and en_out = 0 immediately.
  - Deassertion is taken on clk like any other cycle.
- Synchroniser: SYNC_STAGES flops per line. An extra flop s_d holds the previous synchronised value. The rise term is rise[i] = s[i] & ~s_d[i].
- Latency, SYNC_STAGES=2: req_in high and stable before edge E0 gives rise after E1, pending set at E2, a_out/en_out valid after E2. Total: 3 rising edges. SYNC_STAGES=3 adds one edge.
- Edge mode, per bit i, each edge:
  - set = rise[i]; clr = ack_valid & (ack_idx == i).
  - pending[i] <= set | (pending[i] & ~clr).
  - Set and clear in the same cycle: set wins, bit stays 1, no overflow.
  - rise[i] while pending[i]=1 and no clear that cycle: overflow[i] <= 1.
- Level mode: pending <= s (synchronised level) each edge. ack_valid is ignored and overflow is never set.
- Mode change: edge_mode is registered internally. On any cycle where it differs from the registered copy, pending <= 0 and overflow is held. Normal capture resumes the next cycle.
- ack_idx >= N: no effect.
- Ack of a bit that is not pending: no effect, no error.
- Overflow: sticky until clr_ovf. If clr_ovf and a new overflow event coincide on a bit, set wins.
- Outputs:
  - a_out = pending & mask, combinational from registers.
  - en_out = |a_out.
  - Mask does not affect capture or overflow. A masked pending bit stays pending and appears on a_out once unmasked.
- Reset mid-operation: all state lost. Requests held high across reset are re-captured in level mode. In edge mode they are captured only if req_in is high when synchroniser output first rises after reset, which counts as an edge from 0.
- All updates are in a single always_ff block with an asynchronous reset branch. No latches, no X on outputs in any state.

Decomposition:
- Shared package irq_pkg:
  - localparams N_REQ=8 and IDX_W=3.
  - typedef req_vec_t (logic [N_REQ-1:0]).
  - typedef req_idx_t (logic [IDX_W-1:0]).
- One sub-module, sync_bit_vec: parameterised width and depth multi-flop synchroniser with asynchronous active-low reset. It is instantiated once for req_in and is reusable by other request-facing blocks.

Test Plan:
1. Reset then edge_mode=1, mask=8'hFF; pulse req_in[5] high for 1 edge then low -> pending=8'h20 and a_out=8'h20, en_out=1 after 3rd edge; holds after req_in falls.
2. pending=8'h20; ack_valid=1, ack_idx=5 for one cycle -> pending=8'h00, en_out=0 next edge. Repeat with a new rise on bit 5 in the ack cycle -> pending stays 8'h20, overflow=0.
3. pending[3]=1; second rising edge on req_in[3] without ack -> overflow=8'h08; clr_ovf pulse -> overflow=8'h00. clr_ovf coincident with a new overflow on bit 3 -> overflow stays 8'h08.
4. edge_mode=1, pending=8'h81, mask=8'h01 -> a_out=8'h01, en_out=1. Set mask=8'h00 -> a_out=0, en_out=0, pending still 8'h81. Restore mask=8'hFF -> a_out=8'h81.
5. Level mode: req_in=8'h14 held -> pending=8'h14 after 3 edges; ack_valid to bit 2 ignored; req_in=0 -> pending=0 three edges later. Toggle edge_mode -> pending cleared in that cycle.
6. Assert rst_n=0 asynchronously mid-clock with pending=8'hFF and overflow=8'h0F -> all outputs 0 before the next clk edge. Release rst_n -> no spurious pending with req_in=0.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt request path feeding the 8-input priority encoder.
package irq_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef logic [N_REQ-1:0] req_vec_t;
  typedef logic [IDX_W-1:0] req_idx_t;

endpackage

// File: rtl/sync_bit_vec.sv
// Multi-flop synchroniser for a vector of independent asynchronous bits.
// Each bit is synchronised on its own; no cross-bit coherency is implied.
module sync_bit_vec #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  // Shift chain: stage[0] may go metastable, later stages give it time to settle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) stage[k] <= '0;
    end else begin
      stage[0] <= d;
      for (int k = 1; k < DEPTH; k++) stage[k] <= stage[k-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/irq_request_latch.sv
// Captures synchronised request lines as pending bits (edge or level mode), tracks
// overflow on re-requests, and presents the masked vector to the priority encoder.
module irq_request_latch #(
  parameter int N           = irq_pkg::N_REQ,
  parameter int IDX_W       = irq_pkg::IDX_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req_in,
  input  logic [N-1:0]     mask,
  input  logic             edge_mode,
  input  logic             ack_valid,
  input  logic [IDX_W-1:0] ack_idx,
  input  logic             clr_ovf,
  output logic [N-1:0]     a_out,
  output logic             en_out,
  output logic [N-1:0]     pending,
  output logic [N-1:0]     overflow
);

  import irq_pkg::*;

  logic [N-1:0] s;
  logic [N-1:0] s_d;
  logic [N-1:0] rise;
  logic [N-1:0] ack_vec;
  logic [N-1:0] pending_q;
  logic [N-1:0] overflow_q;
  logic         edge_mode_q;

  sync_bit_vec #(
    .WIDTH(N),
    .DEPTH(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (req_in),
    .q    (s)
  );

  assign rise = s & ~s_d;

  // Index values at or beyond N match no bit, so out-of-range acks fall through harmlessly.
  always_comb begin
    ack_vec = '0;
    for (int i = 0; i < N; i++) begin
      if (ack_valid && (int'(ack_idx) == i)) ack_vec[i] = 1'b1;
    end
  end

  // A mode switch flushes pending so stale level/edge state never leaks across modes.
  // In edge mode a fresh rise beats a same-cycle ack, and a new overflow beats clr_ovf.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_d         <= '0;
      edge_mode_q <= 1'b0;
      pending_q   <= '0;
      overflow_q  <= '0;
    end else begin
      s_d         <= s;
      edge_mode_q <= edge_mode;
      if (edge_mode != edge_mode_q) begin
        pending_q <= '0;
      end else if (edge_mode) begin
        pending_q  <= rise | (pending_q & ~ack_vec);
        overflow_q <= (overflow_q & ~{N{clr_ovf}}) | (rise & pending_q & ~ack_vec);
      end else begin
        pending_q  <= s;
        overflow_q <= overflow_q & ~{N{clr_ovf}};
      end
    end
  end

  assign pending  = pending_q;
  assign overflow = overflow_q;
  assign a_out    = pending_q & mask;
  assign en_out   = |a_out;

endmodule

// File: tb/tb_irq_request_latch.sv
// Directed bench for irq_request_latch: inputs change and outputs are sampled on the falling edge.
module tb_irq_request_latch;

  import irq_pkg::*;

  logic     clk;
  logic     rst_n;
  req_vec_t req_in;
  req_vec_t mask;
  logic     edge_mode;
  logic     ack_valid;
  req_idx_t ack_idx;
  logic     clr_ovf;
  req_vec_t a_out;
  logic     en_out;
  req_vec_t pending;
  req_vec_t overflow;

  int vectors    = 0;
  int miscompares = 0;

  irq_request_latch #(
    .N(N_REQ),
    .IDX_W(IDX_W),
    .SYNC_STAGES(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_in   (req_in),
    .mask     (mask),
    .edge_mode(edge_mode),
    .ack_valid(ack_valid),
    .ack_idx  (ack_idx),
    .clr_ovf  (clr_ovf),
    .a_out    (a_out),
    .en_out   (en_out),
    .pending  (pending),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] req, input logic [7:0] msk, input logic em,
                               input logic av, input logic [2:0] ai, input logic co);
    req_in    = req;
    mask      = msk;
    edge_mode = em;
    ack_valid = av;
    ack_idx   = ai;
    clr_ovf   = co;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves the rise term active for the next edge; one more cycle captures it.
  task automatic pulseReq(input logic [7:0] bits, input logic [7:0] msk);
    applyStimulus(bits, msk, 1'b1, 1'b0, 3'd0, 1'b0);
    cycles(1);
    applyStimulus(8'h00, msk, 1'b1, 1'b0, 3'd0, 1'b0);
    cycles(1);
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(8'h00, 8'hFF, 1'b1, 1'b0, 3'd0, 1'b0);
    #1;
    checkOutput("reset_pending", pending, 8'h00);
    checkOutput("reset_overflow", overflow, 8'h00);
    checkOutput("reset_a_out", a_out, 8'h00);
    checkOutput("reset_en_out", {7'd0, en_out}, 8'h00);
    cycles(2);
    rst_n = 1'b1;
    cycles(2);

    // Single-edge pulse on bit 5: 3-edge latency then held
    applyStimulus(8'h20, 8'hFF, 1'b1, 1'b0, 3'd0, 1'b0);
    cycles(1);
    applyStimulus(8'h00, 8'hFF, 1'b1, 1'b0, 3'd0, 1'b0);
    cycles(1);
    checkOutput("t1_latency_pending", pending, 8'h00);
    cycles(1);
    checkOutput("t1_pending", pending, 8'h20);
    checkOutput("t1_a_out", a_out, 8'h20);
    checkOutput("t1_en_out", {7'd0, en_out}, 8'h01);
    cycles(3);
    checkOutput("t1_hold", pending, 8'h20);

    // Ack clears; ack coinciding with a new rise keeps the bit without overflow
    applyStimulus(8'h00, 8'hFF, 1'b1, 1'b1, 3'd5, 1'b0);
    cycles(1);
    applyStimulus(8'h00, 8'hFF, 1'b1, 1'b0, 3'd0, 1'b0);
    checkOutput("t2_ack_pending", pending, 8'h00);
    checkOutput("t2_ack_en_out", {7'd0, en_out}, 8'h00);
    pulseReq(8'h20, 8'hFF);
    cycles(1);
    checkOutput("t2_recapture", pending, 8'h20);
    pulseReq(8'h20, 8'hFF);
    applyStimulus(8'h00, 8'hFF, 1'b1, 1'b1, 3'd5, 1'b0);
    cycles(1);
    applyStimulus(8'h00, 8'hFF, 1'b1, 1'b0, 3'd0, 1'b0);
    checkOutput("t2_setwins_pending", pending, 8'h20);
    checkOutput("t2_setwins_overflow", overflow, 8'h00);
    applyStimulus(8'h00, 8'hFF, 1'b1, 1'b1, 3'd5, 1'b0);
    cycles(1);
    applyStimulus(8'h00, 8'hFF, 1'b1, 1'b1, 3'd1, 1'b0);
    cycles(1);
    applyStimulus(8'h00, 8'hFF, 1'b1, 1'b0, 3'd0, 1'b0);
    checkOutput("t2_ack_idle_bit", pending, 8'h00);

    // Overflow on bit 3, clear, then clr_ovf racing a new overflow
    pulseReq(8'h08, 8'hFF);
    cycles(1);
    checkOutput("t3_pending", pending, 8'h08);
    pulseReq(8'h08, 8'hFF);
    cycles(1);
    checkOutput("t3_overflow", overflow, 8'h08);
    checkOutput("t3_pending_kept", pending, 8'h08);
    applyStimulus(8'h00, 8'hFF, 1'b1, 1'b0, 3'd0, 1'b1);
    cycles(1);
    checkOutput("t3_clr_ovf", overflow, 8'h00);
    pulseReq(8'h08, 8'hFF);
    applyStimulus(8'h00, 8'hFF, 1'b1, 1'b0, 3'd0, 1'b1);
    cycles(1);
    checkOutput("t3_ovf_wins", overflow, 8'h08);
    applyStimulus(8'h00, 8'hFF, 1'b1, 1'b1, 3'd3, 1'b1);
    cycles(1);
    applyStimulus(8'h00, 8'hFF, 1'b1, 1'b0, 3'd0, 1'b0);
    checkOutput("t3_clean_pending", pending, 8'h00);
    checkOutput("t3_clean_overflow", overflow, 8'h00);

    // Mask only gates the output, not the pending state
    pulseReq(8'h81, 8'h01);
    cycles(1);
    checkOutput("t4_a_out_masked", a_out, 8'h01);
    checkOutput("t4_en_out", {7'd0, en_out}, 8'h01);
    applyStimulus(8'h00, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0);
    cycles(1);
    checkOutput("t4_a_out_zero", a_out, 8'h00);
    checkOutput("t4_en_out_zero", {7'd0, en_out}, 8'h00);
    checkOutput("t4_pending_kept", pending, 8'h81);
    applyStimulus(8'h00, 8'hFF, 1'b1, 1'b0, 3'd0, 1'b0);
    cycles(1);
    checkOutput("t4_a_out_unmask", a_out, 8'h81);
    applyStimulus(8'h00, 8'hFF, 1'b1, 1'b1, 3'd0, 1'b0);
    cycles(1);
    applyStimulus(8'h00, 8'hFF, 1'b1, 1'b1, 3'd7, 1'b0);
    cycles(1);
    applyStimulus(8'h00, 8'hFF, 1'b1, 1'b0, 3'd0, 1'b0);
    checkOutput("t4_clean", pending, 8'h00);

    // Level mode follows the synchronised level and ignores acks
    applyStimulus(8'h14, 8'hFF, 1'b0, 1'b0, 3'd0, 1'b0);
    cycles(2);
    checkOutput("t5_level_latency", pending, 8'h00);
    cycles(1);
    checkOutput("t5_level_pending", pending, 8'h14);
    applyStimulus(8'h14, 8'hFF, 1'b0, 1'b1, 3'd2, 1'b0);
    cycles(1);
    applyStimulus(8'h14, 8'hFF, 1'b0, 1'b0, 3'd0, 1'b0);
    checkOutput("t5_ack_ignored", pending, 8'h14);
    applyStimulus(8'h00, 8'hFF, 1'b0, 1'b0, 3'd0, 1'b0);
    cycles(2);
    checkOutput("t5_fall_latency", pending, 8'h14);
    cycles(1);
    checkOutput("t5_fall", pending, 8'h00);
    applyStimulus(8'h14, 8'hFF, 1'b0, 1'b0, 3'd0, 1'b0);
    cycles(3);
    checkOutput("t5_relevel", pending, 8'h14);
    applyStimulus(8'h14, 8'hFF, 1'b1, 1'b0, 3'd0, 1'b0);
    cycles(1);
    checkOutput("t5_mode_flush", pending, 8'h00);
    cycles(1);
    checkOutput("t5_no_rise_after", pending, 8'h00);
    applyStimulus(8'h00, 8'hFF, 1'b1, 1'b0, 3'd0, 1'b0);
    cycles(3);

    // Asynchronous reset mid-cycle with state loaded
    pulseReq(8'hFF, 8'hFF);
    cycles(1);
    checkOutput("t6_pending_full", pending, 8'hFF);
    pulseReq(8'h0F, 8'hFF);
    cycles(1);
    checkOutput("t6_overflow", overflow, 8'h0F);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_pending", pending, 8'h00);
    checkOutput("t6_rst_overflow", overflow, 8'h00);
    checkOutput("t6_rst_a_out", a_out, 8'h00);
    checkOutput("t6_rst_en_out", {7'd0, en_out}, 8'h00);
    cycles(1);
    rst_n = 1'b1;
    cycles(4);
    checkOutput("t6_no_spurious", pending, 8'h00);
    checkOutput("t6_no_spurious_en", {7'd0, en_out}, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
